// File: rtl/data_ram_bytelane.sv
// Byte-lane data RAM for the single-cycle CPU: sized loads/stores, alignment and range
// checking, sticky first-fault capture and a post-reset clear sequencer.
module data_ram_bytelane #(
    parameter int unsigned RAM_SIZE       = 256,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    input  logic [1:0]  Size,
    input  logic        Signed,
    output logic [31:0] RdData,
    output logic        Busy,
    output logic        AddrErr,
    output logic        ErrValid,
    output logic [31:0] ErrAddr
);
    localparam int unsigned IdxW     = $clog2(RAM_SIZE);
    localparam logic [29:0] RamWords = 30'(RAM_SIZE);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(RAM_SIZE - 1);

    typedef enum logic {StClear, StIdle} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [31:0]       mem [RAM_SIZE];

    logic [IdxW-1:0]   word_idx;
    logic [1:0]        lane;
    logic              acc;
    logic              bad;
    logic              we;
    logic [31:0]       old_word;
    logic [31:0]       wr_lanes;
    logic [31:0]       wr_word;
    logic [3:0]        be;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign word_idx = Addr[IdxW+1:2];
    assign lane     = Addr[1:0];
    assign old_word = mem[word_idx];
    assign Busy     = (state_q == StClear);
    assign acc      = (MemRd | MemWr) & ~Busy;
    assign AddrErr  = acc & bad;
    assign we       = MemWr & ~Busy & ~AddrErr;

    always_comb begin
        bad = (Addr[31:2] >= RamWords);
        unique case (Size)
            2'b00:   bad = bad;
            2'b01:   bad = bad | Addr[0];
            2'b10:   bad = bad | (lane != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    // Replicate the store data across lanes so the byte enables alone pick the target lanes.
    always_comb begin
        be       = 4'b0000;
        wr_lanes = WrData;
        unique case (Size)
            2'b00: begin
                be       = 4'b0001 << lane;
                wr_lanes = {4{WrData[7:0]}};
            end
            2'b01: begin
                be       = Addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{WrData[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_word[8*i +: 8] = be[i] ? wr_lanes[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    always_comb begin
        byte_sel = old_word[{lane, 3'b000} +: 8];
        half_sel = Addr[1] ? old_word[31:16] : old_word[15:0];
        RdData   = 32'h0;
        if (MemRd && !Busy && !AddrErr) begin
            unique case (Size)
                2'b00:   RdData = {{24{Signed & byte_sel[7]}}, byte_sel};
                2'b01:   RdData = {{16{Signed & half_sel[15]}}, half_sel};
                2'b10:   RdData = old_word;
                default: RdData = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CLEAR_ON_RESET ? StClear : StIdle;
            idx_q    <= '0;
            ErrValid <= 1'b0;
            ErrAddr  <= 32'h0;
        end else begin
            if (state_q == StClear) begin
                idx_q <= idx_q + 1'b1;
                if (idx_q == LastIdx) state_q <= StIdle;
            end
            if (AddrErr && !ErrValid) begin
                ErrValid <= 1'b1;
                ErrAddr  <= Addr;
            end
        end
    end

    // Array has no reset; only the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StClear) mem[idx_q] <= 32'h0;
            else if (we)            mem[word_idx] <= wr_word;
        end
    end
endmodule

// File: tb/tb_data_ram_bytelane.sv
// Scoreboard bench for data_ram_bytelane: directed accesses queue their expected
// RdData/AddrErr, a negedge monitor compares whenever a request is on the bus.
module tb_data_ram_bytelane;
    logic        clk = 1'b0;
    logic        reset;
    logic        MemRd, MemWr, Signed;
    logic [31:0] Addr, WrData;
    logic [1:0]  Size;
    logic [31:0] RdData, ErrAddr;
    logic        Busy, AddrErr, ErrValid;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    data_ram_bytelane #(.RAM_SIZE(256), .CLEAR_ON_RESET(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRd    (MemRd),
        .MemWr    (MemWr),
        .Addr     (Addr),
        .WrData   (WrData),
        .Size     (Size),
        .Signed   (Signed),
        .RdData   (RdData),
        .Busy     (Busy),
        .AddrErr  (AddrErr),
        .ErrValid (ErrValid),
        .ErrAddr  (ErrAddr)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a request on the bus consumes one scoreboard entry.
    always @(negedge clk) begin
        if (MemRd || MemWr) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_access: no expected entry, RdData=%h AddrErr=%b",
                         RdData, AddrErr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (RdData !== e.rd || AddrErr !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: got RdData=%h AddrErr=%b, want RdData=%h AddrErr=%b",
                             e.name, RdData, AddrErr, e.rd, e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle bus access; inputs are driven at posedge+1 and sampled by the monitor.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                          input logic sg, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        e.name = name;
        e.rd   = exp_rd;
        e.err  = exp_err;
        sb.push_back(e);
        MemRd  = rd;
        MemWr  = wr;
        Addr   = a;
        WrData = wd;
        Size   = sz;
        Signed = sg;
        tick();
        MemRd  = 1'b0;
        MemWr  = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Counts sampled Busy-high cycles after reset release, bounded.
    task automatic count_busy(input string name);
        int cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!Busy) break;
            cnt++;
        end
        #1;
        chk(name, 32'(cnt), 32'd256);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        MemRd  = 1'b0;
        MemWr  = 1'b0;
        Addr   = 32'h0;
        WrData = 32'h0;
        Size   = 2'b10;
        Signed = 1'b0;
        tick();
        chk("rst_busy",     32'(Busy),     32'd1);
        chk("rst_rddata",   RdData,        32'h0);
        chk("rst_addrerr",  32'(AddrErr),  32'd0);
        chk("rst_errvalid", 32'(ErrValid), 32'd0);
        chk("rst_erraddr",  ErrAddr,       32'h0);
        tick();
        reset = 1'b0;
        count_busy("busy_len_initial");

        access("sw_preload",   1'b0, 1'b1, 32'h14, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0, 1'b0);
        access("lw_preload",   1'b1, 1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b0);
        pulse_reset();
        count_busy("busy_len_clear");
        access("lw_cleared",   1'b1, 1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);

        // Busy gating, then restart the clear at cycle 100.
        pulse_reset();
        repeat (10) tick();
        access("sw_while_busy", 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0);
        access("sw_busy_misaligned", 1'b0, 1'b1, 32'h2, 32'h1, 2'b10, 1'b0, 32'h0, 1'b0);
        repeat (88) tick();
        chk("busy_before_restart", 32'(Busy), 32'd1);
        pulse_reset();
        count_busy("busy_len_restart");
        chk("no_fault_while_busy", 32'(ErrValid), 32'd0);
        access("lw_after_gated", 1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);

        // Byte lanes
        access("sw_20",  1'b0, 1'b1, 32'h20, 32'h1122_3344, 2'b10, 1'b0, 32'h0, 1'b0);
        access("sb_22",  1'b0, 1'b1, 32'h22, 32'h0000_00AA, 2'b00, 1'b0, 32'h0, 1'b0);
        access("lw_20",  1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11AA_3344, 1'b0);
        access("lbu_22", 1'b1, 1'b0, 32'h22, 32'h0, 2'b00, 1'b0, 32'h0000_00AA, 1'b0);
        access("lb_22",  1'b1, 1'b0, 32'h22, 32'h0, 2'b00, 1'b1, 32'hFFFF_FFAA, 1'b0);
        access("lb_23",  1'b1, 1'b0, 32'h23, 32'h0, 2'b00, 1'b1, 32'h0000_0011, 1'b0);

        // Halves
        access("sh_42",  1'b0, 1'b1, 32'h42, 32'h1234_8001, 2'b01, 1'b0, 32'h0, 1'b0);
        access("lw_40",  1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h8001_0000, 1'b0);
        access("lh_42",  1'b1, 1'b0, 32'h42, 32'h0, 2'b01, 1'b1, 32'hFFFF_8001, 1'b0);
        access("lhu_42", 1'b1, 1'b0, 32'h42, 32'h0, 2'b01, 1'b0, 32'h0000_8001, 1'b0);
        access("lh_40",  1'b1, 1'b0, 32'h40, 32'h0, 2'b01, 1'b1, 32'h0000_0000, 1'b0);

        // Same-cycle read and write
        access("sw_8_init", 1'b0, 1'b1, 32'h8, 32'h9, 2'b10, 1'b0, 32'h0, 1'b0);
        access("rdwr_8",    1'b1, 1'b1, 32'h8, 32'h5, 2'b10, 1'b0, 32'h9, 1'b0);
        access("lw_8_new",  1'b1, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 32'h5, 1'b0);

        // Top of range is legal
        access("sw_last",   1'b0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0, 1'b0);
        access("lw_last",   1'b1, 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0);

        // Faults
        chk("errvalid_pre_fault", 32'(ErrValid), 32'd0);
        access("sw_misaligned", 1'b0, 1'b1, 32'h22, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0, 1'b1);
        chk("errvalid_set",  32'(ErrValid), 32'd1);
        chk("erraddr_first", ErrAddr,       32'h22);
        access("lw_unchanged", 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h11AA_3344, 1'b0);
        access("lw_oor",       1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        chk("erraddr_sticky", ErrAddr, 32'h22);
        access("size_11",      1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
        access("lh_odd",       1'b1, 1'b0, 32'h21, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1);
        access("sb_oor",       1'b0, 1'b1, 32'h401, 32'h77, 2'b00, 1'b0, 32'h0, 1'b1);
        access("lw_0_intact",  1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
        chk("erraddr_final", ErrAddr, 32'h22);

        tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_ram_bytelane.md
Name: data_ram_bytelane

Overview:
Parametrised successor to the single-cycle CPU data RAM, sitting on the same MemRd/MemWr/Addr/WrData bus. It adds byte/halfword/word stores and loads with sign or zero extension, and alignment and range checking. It also adds a sticky fault-address capture register and a post-reset clear sequencer that zeroes the array one word per cycle. Reads stay combinational, so the single-cycle datapath timing is unchanged.

Parameters:
RAM_SIZE, 256, number of 32-bit words; must be a power of two, at least 2.
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents untouched, ready immediately.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
MemRd  input  1  load request.
MemWr  input  1  store request.
Addr  input  32  byte address.
WrData  input  32  store data; the byte/half is taken from the LSBs.
Size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
Signed  input  1  1 = sign-extend loads, 0 = zero-extend; ignored for word loads and stores.
RdData  output  32  load result (combinational).
Busy  output  1  clear sequence in progress; all accesses are ignored.
AddrErr  output  1  current access is faulting (combinational).
ErrValid  output  1  sticky flag: a fault has occurred since reset.
ErrAddr  output  32  Addr of the first fault since reset.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. Nothing is asynchronous.
- FSM has two states, CLEAR and IDLE, plus a clear index idx of width log2(RAM_SIZE).
- Posedge with reset = 1:
  - ErrValid <= 0, ErrAddr <= 0, idx <= 0.
  - state <= CLEAR if CLEAR_ON_RESET, else IDLE.
- CLEAR, each posedge with reset = 0:
  - RAM[idx] <= 0, idx <= idx + 1.
  - When idx == RAM_SIZE-1 is written, state <= IDLE.
  - Busy therefore stays high through reset plus exactly RAM_SIZE cycles after reset falls.
  - Reset asserted mid-clear restarts the sequence from idx 0.
- Busy = (state == CLEAR). RAM contents are undefined before the clear completes.
- Reset values: Busy = CLEAR_ON_RESET, RdData = 0, AddrErr = 0, ErrValid = 0, ErrAddr = 0.
- Access qualifier: acc = (MemRd | MemWr) & ~Busy. Both MemRd and MemWr high is legal: the read returns pre-write data.
- Word index is Addr[31:2]; lane is Addr[1:0]; byte order is little-endian.
- AddrErr = acc & (bad), where bad is any of:
  - Addr[31:2] >= RAM_SIZE;
  - Size == 11;
  - Size == 01 with Addr[0] = 1;
  - Size == 10 with Addr[1:0] != 0.
- Store: on posedge with MemWr & ~Busy & ~AddrErr & ~reset, write only the addressed lanes.
  - Byte: lane Addr[1:0] <= WrData[7:0].
  - Half: lanes Addr[1]*2 and Addr[1]*2+1 <= WrData[15:0].
  - Word: all four lanes.
  - All other lanes hold their value. A faulting store writes nothing.
- Load: RdData = 0 unless MemRd & ~Busy & ~AddrErr.
  - Byte: selected byte, extended to 32 bits.
  - Half: selected half, extended to 32 bits.
  - Word: raw word.
- Read-during-write to the same word: RdData shows the old contents until the edge.
- Fault capture: on posedge with AddrErr & ~ErrValid & ~reset, ErrValid <= 1 and ErrAddr <= Addr. Later faults do not overwrite; only reset clears.

Test Plan:
- Clear: RAM_SIZE = 256; preload RAM[5] = FFFFFFFF; pulse reset for 1 cycle -> Busy = 1 for exactly 256 cycles after reset falls, then 0; lw at 0x14 -> 00000000. Repeat with reset re-asserted at clear cycle 100 -> Busy lasts another full 256 cycles.
- Byte lanes: sw 0x11223344 @0x20; sb WrData = 0xAA @0x22 -> lw @0x20 = 0x11AA3344. lbu @0x22 = 0x000000AA. lb @0x22 = 0xFFFFFFAA.
- Halves: sh WrData = 0x8001 @0x42 over word 0 -> lw @0x40 = 0x80010000. lh @0x42 = 0xFFFF8001. lhu @0x42 = 0x00008001.
- Faults: sw @0x22 -> AddrErr = 1, memory unchanged. ErrValid = 1 and ErrAddr = 0x22 the next cycle. Then lw @0x400 (out of range) -> AddrErr = 1, RdData = 0, ErrAddr stays 0x22. Size = 11 also gives AddrErr = 1.
- Busy gating: during clear, sw 0xDEADBEEF @0x0 -> AddrErr = 0, no fault captured, RdData = 0. After clear, lw @0x0 = 0.
- Same-cycle MemRd & MemWr: sw 0x5 @0x8 with MemRd = 1 while the word holds 0x9 -> RdData = 0x9 in that cycle, 0x5 the next cycle.
